// File: rtl/rv_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : rv_pkg                                                       |
// | Description : Shared fetch-stage definitions: datapath width, fetch FSM    |
// |               state encoding and the compressed-instruction test.          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package rv_pkg;

  // Address/data width; only 32 is supported by the fetch stage.
  localparam int XLEN = 32;

  // Fetch FSM states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,  // no request outstanding
    ST_REQ  = 2'd1,  // request outstanding, response will be kept
    ST_DROP = 2'd2   // request outstanding, response will be thrown away
  } fetch_state_e;

  // Low two bits of a full-width (32-bit) instruction.
  localparam logic [1:0] RVC_MASK = 2'b11;

  // A halfword starts a compressed instruction unless its low bits are 11.
  function automatic logic is_rvc(input logic [15:0] h);
    return (h[1:0] & RVC_MASK) != RVC_MASK;
  endfunction

endpackage
`default_nettype wire

// File: rtl/if_align_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface   : if_align_if                                                  |
// | Description : Word-wide instruction memory read bus.                       |
// |   imem_req    - read request, held until the response                      |
// |   imem_addr   - word address, stable while imem_req is high                |
// |   imem_rvalid - response valid (single cycle)                              |
// |   imem_rdata  - response word                                              |
// |   master : fetch stage side      slave : memory side                       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface if_align_if;
  import rv_pkg::*;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_rvalid;
  logic [31:0]     imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rvalid,
    output imem_rdata
  );

endinterface
`default_nettype wire

// File: rtl/rvc_extract.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : rvc_extract                                                  |
// | Description : Combinational hit selection and halfword assembly over the   |
// |               two-word line buffer.                                        |
// |   pc_hw     in  fetch address without bit 0                                |
// |   base      in  word address of entry W0 (W1 sits at base+4)               |
// |   w0/w1     in  buffer words, with w0_valid/w1_valid                       |
// |   instr     out aligned instruction (RVC zero-extended)                    |
// |   instr_rvc out instruction is compressed                                  |
// |   need_hi   out a 32-bit instruction straddles into the following word     |
// |   hit       out every word the instruction needs is present                |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module rvc_extract
  import rv_pkg::*;
(
  input  logic [XLEN-1:1] pc_hw,
  input  logic [XLEN-1:0] base,
  input  logic [31:0]     w0,
  input  logic            w0_valid,
  input  logic [31:0]     w1,
  input  logic            w1_valid,
  output logic [31:0]     instr,
  output logic            instr_rvc,
  output logic            need_hi,
  output logic            hit
);

  logic [XLEN-1:0] p;
  logic [XLEN-1:0] base_nx;
  logic            sel_w0;
  logic            sel_w1;
  logic            have_low;
  logic [31:0]     low;
  logic [15:0]     h;

  always_comb begin
    p         = {pc_hw[XLEN-1:2], 2'b00};
    base_nx   = base + XLEN'(4);
    sel_w0    = (p == base) && w0_valid;
    sel_w1    = !sel_w0 && (p == base_nx) && w1_valid;
    have_low  = sel_w0 || sel_w1;
    low       = sel_w1 ? w1 : w0;
    h         = pc_hw[1] ? low[31:16] : low[15:0];
    instr_rvc = is_rvc(h);
    need_hi   = have_low && !instr_rvc && pc_hw[1];

    if (instr_rvc) begin
      instr = {16'h0000, h};
    end else if (!pc_hw[1]) begin
      instr = low;
    end else begin
      instr = {w1[15:0], h};
    end

    // The upper half of a straddling instruction can only come from W1 when
    // the low word is W0; a straddle starting in W1 is always a miss.
    hit = have_low && (!need_hi || (sel_w0 && w1_valid));
  end

endmodule
`default_nettype wire

// File: rtl/if_align.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : if_align                                                     |
// | Description : Fetch/realignment stage. Returns one complete 16- or 32-bit  |
// |               instruction for the current halfword-aligned pc from a       |
// |               two-word line buffer filled over a word-wide memory bus.     |
// |   clock, reset      clock (posedge) and asynchronous active-high reset     |
// |   pc, flush         fetch address and redirect                             |
// |   imem              memory read bus (master side)                          |
// |   instr, instr_pc   aligned instruction and its address                    |
// |   instr_valid       instruction complete for pc                            |
// |   instr_rvc         instruction is compressed                              |
// |   fetch_stall       inverse of instr_valid                                 |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module if_align
  import rv_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic [XLEN-1:0]   pc,
  input  logic              flush,
  if_align_if.master        imem,
  output logic [31:0]       instr,
  output logic [XLEN-1:0]   instr_pc,
  output logic              instr_valid,
  output logic              instr_rvc,
  output logic              fetch_stall
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] base_q, base_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [31:0]     w0_q, w0_d, w1_q, w1_d;
  logic            w0_v_q, w0_v_d, w1_v_q, w1_v_d;
  logic            req_q, req_d;

  logic [XLEN-1:0] p;
  logic [XLEN-1:0] base_nx;
  logic [XLEN-1:0] miss_addr;
  logic            hit;
  logic            need_hi;
  logic            shift;

  rvc_extract u_rvc_extract (
    .pc_hw     (pc[XLEN-1:1]),
    .base      (base_q),
    .w0        (w0_q),
    .w0_valid  (w0_v_q),
    .w1        (w1_q),
    .w1_valid  (w1_v_q),
    .instr     (instr),
    .instr_rvc (instr_rvc),
    .need_hi   (need_hi),
    .hit       (hit)
  );

  assign instr_pc      = pc;
  assign instr_valid   = hit && !flush;
  assign fetch_stall   = !instr_valid;
  assign imem.imem_req  = req_q;
  assign imem.imem_addr = addr_q;

  always_comb begin
    p         = {pc[XLEN-1:2], 2'b00};
    base_nx   = base_q + XLEN'(4);
    // A miss with a low word present can only be a straddle needing P+4.
    miss_addr = need_hi ? (p + XLEN'(4)) : p;
    // Slide the line forward once pc has moved into W1. W0 need not be valid:
    // keeping W1 as the new low word lets a straddle out of it fetch the
    // following word into the new W1 slot instead of chasing base+8.
    shift     = (p == base_nx) && w1_v_q && !flush;
  end

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    addr_d  = addr_q;
    w0_d    = w0_q;
    w1_d    = w1_q;
    w0_v_d  = w0_v_q;
    w1_v_d  = w1_v_q;
    req_d   = req_q;

    if (shift) begin
      w0_d   = w1_q;
      w0_v_d = 1'b1;
      w1_v_d = 1'b0;
      base_d = base_nx;
    end

    if (flush) begin
      w0_v_d = 1'b0;
      w1_v_d = 1'b0;
    end

    unique case (state_q)
      ST_IDLE: begin
        // A flush cycle only invalidates; the redirected miss goes out next.
        if (!flush) begin
          if (!hit) begin
            if ((p != base_q) && (p != base_nx)) begin
              base_d = p;
              w0_v_d = 1'b0;
              w1_v_d = 1'b0;
            end
            req_d   = 1'b1;
            addr_d  = miss_addr;
            state_d = ST_REQ;
          end else if (!w1_v_q && !shift) begin
            req_d   = 1'b1;
            addr_d  = base_nx;
            state_d = ST_REQ;
          end
        end
      end

      ST_REQ: begin
        if (imem.imem_rvalid) begin
          req_d   = 1'b0;
          state_d = ST_IDLE;
          // Slot match uses the post-shift base; stale data is dropped.
          if (!flush) begin
            if (addr_q == base_d) begin
              w0_d   = imem.imem_rdata;
              w0_v_d = 1'b1;
            end else if (addr_q == (base_d + XLEN'(4))) begin
              w1_d   = imem.imem_rdata;
              w1_v_d = 1'b1;
            end
          end
        end else if (flush) begin
          state_d = ST_DROP;
        end
      end

      ST_DROP: begin
        if (imem.imem_rvalid) begin
          req_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      base_q  <= '0;
      addr_q  <= '0;
      w0_q    <= '0;
      w1_q    <= '0;
      w0_v_q  <= 1'b0;
      w1_v_q  <= 1'b0;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      addr_q  <= addr_d;
      w0_q    <= w0_d;
      w1_q    <= w1_d;
      w0_v_q  <= w0_v_d;
      w1_v_q  <= w1_v_d;
      req_q   <= req_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_if_align.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_if_align                                                  |
// | Description : Self-checking bench for if_align: directed scenarios then a  |
// |               randomized instruction stream with redirects, checked        |
// |               against a halfword-level memory model.                       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_if_align;
  import rv_pkg::*;

  logic            clock;
  logic            reset;
  logic [XLEN-1:0] pc;
  logic            flush;
  logic [31:0]     instr;
  logic [XLEN-1:0] instr_pc;
  logic            instr_valid;
  logic            instr_rvc;
  logic            fetch_stall;

  if_align_if bus ();

  if_align dut (
    .clock       (clock),
    .reset       (reset),
    .pc          (pc),
    .flush       (flush),
    .imem        (bus),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .instr_rvc   (instr_rvc),
    .fetch_stall (fetch_stall)
  );

  int          checks = 0;
  int          errors = 0;
  logic [31:0] mem [0:255];
  logic [31:0] req_log [$];
  int          lat_cfg = 2;     // 0 selects a random latency of 1..3
  bit          rsp_lax = 1'b0;  // relax bus-protocol checks around async reset
  bit          busy = 1'b0;
  int          cnt = 0;
  logic [31:0] lat_addr = '0;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: memory viewed as a stream of halfwords.
  function automatic logic [15:0] half_at(input logic [31:0] a);
    logic [31:0] w;
    w = mem[a[9:2]];
    return a[1] ? w[31:16] : w[15:0];
  endfunction

  function automatic logic [31:0] exp_instr(input logic [31:0] a);
    logic [15:0] lo;
    lo = half_at(a);
    if (lo[1:0] != 2'b11) return {16'h0000, lo};
    return {half_at(a + 32'd2), lo};
  endfunction

  // Memory responder with protocol checks.
  initial begin
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = '0;
    forever begin
      @(negedge clock);
      if (bus.imem_rvalid) begin
        bus.imem_rvalid = 1'b0;
        if (!reset) check("req_drop", {31'b0, bus.imem_req}, 32'd0);
      end else if (busy) begin
        if (!reset && !rsp_lax) begin
          check("req_held", {31'b0, bus.imem_req}, 32'd1);
          check("addr_stable", bus.imem_addr, lat_addr);
        end
        cnt--;
        if (cnt == 0) begin
          bus.imem_rvalid = 1'b1;
          bus.imem_rdata  = mem[lat_addr[9:2]];
          busy = 1'b0;
        end
      end else if (bus.imem_req && !reset) begin
        check("addr_align", {30'b0, bus.imem_addr[1:0]}, 32'd0);
        busy     = 1'b1;
        lat_addr = bus.imem_addr;
        req_log.push_back(lat_addr);
        cnt = (lat_cfg == 0) ? int'($urandom_range(1, 3)) : lat_cfg;
      end
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    flush = 1'b0;
    repeat (5) @(negedge clock);
    req_log.delete();
    for (int i = 0; i < 256; i++) mem[i] = 32'h0000_0013;
  endtask

  task automatic wait_valid(input int budget, input string tag);
    int n;
    n = 0;
    while (!instr_valid && n < budget) begin
      @(negedge clock);
      n++;
    end
    check(tag, {31'b0, instr_valid}, 32'd1);
  endtask

  function automatic logic [31:0] log_at(input int i);
    if (i < req_log.size()) return req_log[i];
    return 32'hDEAD_BEEF;
  endfunction

  initial begin
    int          n0;
    int          idle;
    logic [31:0] e;
    reset = 1'b1;
    pc    = '0;
    flush = 1'b0;

    // Cold fetch, 2-cycle memory.
    lat_cfg = 2;
    do_reset();
    mem[0] = 32'h0000_0013;
    pc = 32'h0;
    check("rst_valid", {31'b0, instr_valid}, 32'd0);
    check("rst_stall", {31'b0, fetch_stall}, 32'd1);
    check("rst_req", {31'b0, bus.imem_req}, 32'd0);
    check("rst_addr", bus.imem_addr, 32'd0);
    reset = 1'b0;
    @(negedge clock);
    check("cold_req_c1", {31'b0, bus.imem_req}, 32'd1);
    check("cold_addr_c1", bus.imem_addr, 32'h0);
    @(negedge clock);
    check("cold_valid_c2", {31'b0, instr_valid}, 32'd0);
    @(negedge clock);
    check("cold_valid_c3", {31'b0, instr_valid}, 32'd0);
    @(negedge clock);
    check("cold_valid_c4", {31'b0, instr_valid}, 32'd1);
    check("cold_instr", instr, 32'h0000_0013);
    check("cold_rvc", {31'b0, instr_rvc}, 32'd0);
    check("cold_stall", {31'b0, fetch_stall}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check("cold_stall_hold", {31'b0, fetch_stall}, 32'd0);
    end

    // Back-to-back RVC pair out of one word.
    lat_cfg = 1;
    do_reset();
    mem[0] = 32'h0001_4501;
    pc = 32'h0;
    reset = 1'b0;
    wait_valid(20, "rvc0_timeout");
    check("rvc0_instr", instr, 32'h0000_4501);
    check("rvc0_rvc", {31'b0, instr_rvc}, 32'd1);
    pc = 32'h2;
    @(negedge clock);
    check("rvc1_valid", {31'b0, instr_valid}, 32'd1);
    check("rvc1_instr", instr, 32'h0000_0001);
    check("rvc1_rvc", {31'b0, instr_rvc}, 32'd1);
    n0 = 0;
    foreach (req_log[i]) if (req_log[i] == 32'h0) n0++;
    check("rvc_no_refetch", n0, 32'd1);

    // Straddling 32-bit instruction from a cold buffer.
    do_reset();
    mem[0] = 32'h0513_4501;
    mem[1] = 32'h0000_0000;
    pc = 32'h2;
    reset = 1'b0;
    wait_valid(30, "strad_timeout");
    check("strad_instr", instr, 32'h0000_0513);
    check("strad_rvc", {31'b0, instr_rvc}, 32'd0);
    check("strad_req0", log_at(0), 32'h0);
    check("strad_req1", log_at(1), 32'h4);

    // Flush while the 0x100 miss is outstanding.
    lat_cfg = 3;
    do_reset();
    mem[64]  = 32'h00A0_0093;
    mem[128] = 32'h00B0_0113;
    pc = 32'h100;
    reset = 1'b0;
    @(negedge clock);
    check("fl_req", {31'b0, bus.imem_req}, 32'd1);
    check("fl_addr", bus.imem_addr, 32'h100);
    flush = 1'b1;
    pc = 32'h200;
    #1;
    check("fl_valid_flushcyc", {31'b0, instr_valid}, 32'd0);
    @(negedge clock);
    flush = 1'b0;
    #1;
    check("fl_valid_drop", {31'b0, instr_valid}, 32'd0);
    wait_valid(30, "fl_timeout");
    check("fl_instr", instr, 32'h00B0_0113);
    check("fl_req0", log_at(0), 32'h100);
    check("fl_req1", log_at(1), 32'h200);
    check("fl_nreq", req_log.size(), 32'd2);

    // Asynchronous reset in the middle of a request.
    lat_cfg = 3;
    do_reset();
    mem[16] = 32'h00C0_0193;
    mem[32] = 32'h00D0_0213;
    pc = 32'h40;
    rsp_lax = 1'b1;
    reset = 1'b0;
    @(negedge clock);
    check("ar_req", {31'b0, bus.imem_req}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("ar_req_now", {31'b0, bus.imem_req}, 32'd0);
    check("ar_valid_now", {31'b0, instr_valid}, 32'd0);
    check("ar_stall_now", {31'b0, fetch_stall}, 32'd1);
    @(negedge clock);
    reset = 1'b0;
    flush = 1'b1;
    pc = 32'h80;
    repeat (3) begin
      @(negedge clock);
      check("ar_req_idle", {31'b0, bus.imem_req}, 32'd0);
    end
    flush = 1'b0;
    #1;
    check("ar_late_ignored", {31'b0, instr_valid}, 32'd0);
    wait_valid(30, "ar_timeout");
    check("ar_instr", instr, 32'h00D0_0213);
    check("ar_last_req", log_at(req_log.size() - 1), 32'h80);
    rsp_lax = 1'b0;

    // Straddle across the top of the address space.
    lat_cfg = 1;
    do_reset();
    mem[255] = 32'h1237_0001;
    mem[0]   = 32'h0000_ABCD;
    pc = 32'hFFFF_FFFE;
    reset = 1'b0;
    wait_valid(30, "wrap_timeout");
    check("wrap_instr", instr, exp_instr(32'hFFFF_FFFE));
    check("wrap_req0", log_at(0), 32'hFFFF_FFFC);
    check("wrap_req1", log_at(1), 32'h0);

    // Random stream with redirects and random memory latency.
    lat_cfg = 0;
    do_reset();
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    pc = {22'b0, 9'($urandom_range(0, 511)), 1'b0};
    reset = 1'b0;
    idle = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clock);
      flush = 1'b0;
      #1;
      check("rnd_stall", {31'b0, fetch_stall}, {31'b0, !instr_valid});
      if (instr_valid) begin
        e = exp_instr(pc);
        check("rnd_instr", instr, e);
        check("rnd_rvc", {31'b0, instr_rvc}, {31'b0, e[1:0] != 2'b11});
        check("rnd_pc", instr_pc, pc);
        pc = pc + ((e[1:0] != 2'b11) ? 32'd2 : 32'd4);
        idle = 0;
      end else begin
        idle++;
        if (idle > 40) begin
          check("rnd_progress", {31'b0, instr_valid}, 32'd1);
          break;
        end
      end
      if ($urandom_range(0, 11) == 0) begin
        flush = 1'b1;
        if ($urandom_range(0, 7) == 0)
          pc = 32'hFFFF_FFE0 | {27'b0, 4'($urandom_range(0, 15)), 1'b0};
        else
          pc = {22'b0, 9'($urandom_range(0, 511)), 1'b0};
        #1;
        check("rnd_flush_valid", {31'b0, instr_valid}, 32'd0);
        idle = 0;
      end
    end
    flush = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
